// File: rtl/adsr_poly.sv
// rtl/adsr_poly.sv - polyphonic linear ADSR envelope generator, one voice serviced per clock
module adsr_poly #(
    parameter int VOICES = 4,
    parameter int ENV_W  = 7,
    parameter int TIME_W = 7,
    parameter int ACC_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_rate,
    input  logic [VOICES-1:0]       gate_on,
    input  logic [VOICES-1:0]       gate_off,
    input  logic [TIME_W-1:0]       adsr_a,
    input  logic [TIME_W-1:0]       adsr_d,
    input  logic [ENV_W-1:0]        adsr_s,
    input  logic [TIME_W-1:0]       adsr_r,
    output logic [VOICES*ENV_W-1:0] env_out,
    output logic                    env_dv,
    output logic [VOICES-1:0]       voice_active,
    output logic                    busy,
    output logic                    overrun
);

    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int AW1   = ACC_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);
    localparam logic [ACC_W:0]   MAX_X    = {1'b0, {ACC_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t              state_q [VOICES];
    logic [ACC_W-1:0]    lvl_q   [VOICES];
    logic [VOICES-1:0]   pend_on_q, pend_off_q;
    logic [VOICES-1:0]   pend_on_d, pend_off_d;
    logic [IDX_W-1:0]    idx_q;
    logic                busy_q, env_dv_q, overrun_q;

    state_t              cur_state, svc_state_d;
    logic [ACC_W-1:0]    cur_lvl, svc_lvl_d;
    logic [ACC_W:0]      s_full, sum_a, dif_d, dif_r;
    logic [VOICES-1:0]   svc_mask;

    // Slope per sample: 2^TIME_W - t, so t=0 is the steepest ramp.
    function automatic logic [ACC_W:0] inc(input logic [TIME_W-1:0] t);
        logic [TIME_W:0] s;
        s = {1'b1, {TIME_W{1'b0}}} - {1'b0, t};
        return AW1'(s);
    endfunction

    assign cur_state = state_q[idx_q];
    assign cur_lvl   = lvl_q[idx_q];
    assign s_full    = {1'b0, adsr_s, {(ACC_W-ENV_W){1'b0}}};
    assign sum_a     = {1'b0, cur_lvl} + inc(adsr_a);
    assign dif_d     = {1'b0, cur_lvl} - inc(adsr_d);
    assign dif_r     = {1'b0, cur_lvl} - inc(adsr_r);

    always_comb begin
        svc_state_d = cur_state;
        svc_lvl_d   = cur_lvl;
        if (pend_on_q[idx_q]) begin
            svc_state_d = S_ATTACK;
        end else if (pend_off_q[idx_q] && cur_state != S_IDLE) begin
            svc_state_d = S_RELEASE;
        end else begin
            case (cur_state)
                S_ATTACK: begin
                    if (sum_a >= MAX_X) begin
                        svc_lvl_d   = '1;
                        svc_state_d = S_DECAY;
                    end else begin
                        svc_lvl_d = sum_a[ACC_W-1:0];
                    end
                end
                S_DECAY: begin
                    // Borrow bit set means we crossed zero, which is certainly below sustain.
                    if (dif_d[ACC_W] || dif_d <= s_full) begin
                        svc_lvl_d   = s_full[ACC_W-1:0];
                        svc_state_d = S_SUSTAIN;
                    end else begin
                        svc_lvl_d = dif_d[ACC_W-1:0];
                    end
                end
                S_SUSTAIN: svc_lvl_d = s_full[ACC_W-1:0];
                S_RELEASE: begin
                    if (dif_r[ACC_W] || dif_r == '0) begin
                        svc_lvl_d   = '0;
                        svc_state_d = S_IDLE;
                    end else begin
                        svc_lvl_d = dif_r[ACC_W-1:0];
                    end
                end
                default: begin
                    svc_lvl_d   = '0;
                    svc_state_d = S_IDLE;
                end
            endcase
        end
    end

    // A gate landing on its own service cycle survives into the next sweep.
    always_comb begin
        svc_mask   = VOICES'(busy_q) << idx_q;
        pend_on_d  = (pend_on_q  & ~svc_mask) | gate_on;
        pend_off_d = (pend_off_q & ~svc_mask) | gate_off;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int v = 0; v < VOICES; v++) begin
                state_q[v] <= S_IDLE;
                lvl_q[v]   <= '0;
            end
            pend_on_q  <= '0;
            pend_off_q <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            env_dv_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            env_dv_q   <= 1'b0;
            pend_on_q  <= pend_on_d;
            pend_off_q <= pend_off_d;
            if (busy_q) begin
                state_q[idx_q] <= svc_state_d;
                lvl_q[idx_q]   <= svc_lvl_d;
                if (sample_rate) begin
                    overrun_q <= 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    busy_q   <= 1'b0;
                    env_dv_q <= 1'b1;
                    idx_q    <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end else if (sample_rate) begin
                busy_q <= 1'b1;
                idx_q  <= '0;
            end
        end
    end

    always_comb begin
        env_out      = '0;
        voice_active = '0;
        for (int v = 0; v < VOICES; v++) begin
            env_out[v*ENV_W +: ENV_W] = lvl_q[v][ACC_W-1 -: ENV_W];
            voice_active[v]           = (state_q[v] != S_IDLE);
        end
    end

    assign env_dv  = env_dv_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_adsr_poly.sv
// tb/tb_adsr_poly.sv - vector table plus scoreboard bench for adsr_poly
module tb_adsr_poly;

    localparam int V = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            sample_rate;
    logic [V-1:0]    gate_on, gate_off;
    logic [6:0]      adsr_a, adsr_d, adsr_s, adsr_r;
    logic [V*7-1:0]  env_out;
    logic            env_dv;
    logic [V-1:0]    voice_active;
    logic            busy, overrun;

    adsr_poly dut (
        .clk(clk), .rst(rst), .sample_rate(sample_rate),
        .gate_on(gate_on), .gate_off(gate_off),
        .adsr_a(adsr_a), .adsr_d(adsr_d), .adsr_s(adsr_s), .adsr_r(adsr_r),
        .env_out(env_out), .env_dv(env_dv), .voice_active(voice_active),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [V-1:0]      on;
        logic [V-1:0]      off;
        int                a, d, s, r;
        int                n;
        logic [V-1:0][6:0] env;
        logic [V-1:0]      act;
    } vec_t;

    typedef struct {
        logic [V*7-1:0] env;
        logic [V-1:0]   act;
    } exp_t;

    int     checks = 0;
    int     failures = 0;
    exp_t   sb_q[$];
    vec_t   vecs[15];

    // Reference envelope model: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
    int     m_st[V];
    int     m_lvl[V];
    bit     m_pon[V], m_poff[V];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < V; v++) begin
            m_st[v] = 0; m_lvl[v] = 0; m_pon[v] = 0; m_poff[v] = 0;
        end
    endtask

    task automatic model_step();
        int sf;
        sf = int'(adsr_s) * 512;
        for (int v = 0; v < V; v++) begin
            if (m_pon[v]) m_st[v] = 1;
            else if (m_poff[v] && m_st[v] != 0) m_st[v] = 4;
            else begin
                case (m_st[v])
                    1: begin
                        m_lvl[v] += 128 - int'(adsr_a);
                        if (m_lvl[v] >= 65535) begin m_lvl[v] = 65535; m_st[v] = 2; end
                    end
                    2: begin
                        m_lvl[v] -= 128 - int'(adsr_d);
                        if (m_lvl[v] <= sf) begin m_lvl[v] = sf; m_st[v] = 3; end
                    end
                    3: m_lvl[v] = sf;
                    4: begin
                        m_lvl[v] -= 128 - int'(adsr_r);
                        if (m_lvl[v] <= 0) begin m_lvl[v] = 0; m_st[v] = 0; end
                    end
                    default: m_lvl[v] = 0;
                endcase
            end
            m_pon[v] = 0; m_poff[v] = 0;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        model_step();
        for (int v = 0; v < V; v++) begin
            e.env[v*7 +: 7] = 7'(m_lvl[v] / 512);
            e.act[v]        = (m_st[v] != 0);
        end
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_dv actual=env_dv expected=no_sweep");
        end else begin
            e = sb_q.pop_front();
            if (env_out !== e.env || voice_active !== e.act) begin
                failures++;
                $display("FAIL sb_sweep actual=env %h act %b expected=env %h act %b",
                         env_out, voice_active, e.env, e.act);
            end
        end
    endtask

    task automatic pulse(input logic [V-1:0] on, input logic [V-1:0] off);
        @(posedge clk); #1;
        gate_on = on; gate_off = off;
        @(posedge clk); #1;
        gate_on = '0; gate_off = '0;
        for (int v = 0; v < V; v++) begin
            if (on[v])  m_pon[v]  = 1;
            if (off[v]) m_poff[v] = 1;
        end
    endtask

    task automatic run_sample();
        bit seen;
        push_expected();
        @(posedge clk); #1 sample_rate = 1'b1;
        @(posedge clk); #1 sample_rate = 1'b0;
        seen = 0;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            if (env_dv) begin
                sb_check();
                seen = 1;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL sweep_timeout actual=no_env_dv expected=env_dv");
            sb_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, dv_at, dv_cnt;

        // on, off, a, d, s, r, samples, env {v3,v2,v1,v0}, active
        vecs[0]  = '{4'b0001, 4'b0000, 0, 0, 64, 0,   1, {7'd0, 7'd0, 7'd0,  7'd0},   4'b0001};
        vecs[1]  = '{4'b0000, 4'b0000, 0, 0, 64, 0,   4, {7'd0, 7'd0, 7'd0,  7'd1},   4'b0001};
        vecs[2]  = '{4'b0000, 4'b0000, 0, 0, 64, 0, 508, {7'd0, 7'd0, 7'd0,  7'd127}, 4'b0001};
        vecs[3]  = '{4'b0000, 4'b0000, 0, 0, 64, 0, 256, {7'd0, 7'd0, 7'd0,  7'd64},  4'b0001};
        vecs[4]  = '{4'b0000, 4'b0000, 0, 0, 64, 0,  10, {7'd0, 7'd0, 7'd0,  7'd64},  4'b0001};
        vecs[5]  = '{4'b0000, 4'b0000, 0, 0, 32, 0,   1, {7'd0, 7'd0, 7'd0,  7'd32},  4'b0001};
        vecs[6]  = '{4'b0000, 4'b0001, 0, 0, 32, 0,   1, {7'd0, 7'd0, 7'd0,  7'd32},  4'b0001};
        vecs[7]  = '{4'b0000, 4'b0000, 0, 0, 32, 0, 127, {7'd0, 7'd0, 7'd0,  7'd0},   4'b0001};
        vecs[8]  = '{4'b0000, 4'b0000, 0, 0, 32, 0,   1, {7'd0, 7'd0, 7'd0,  7'd0},   4'b0000};
        vecs[9]  = '{4'b0010, 4'b0000, 0, 0, 32, 127, 162, {7'd0, 7'd0, 7'd40, 7'd0}, 4'b0010};
        vecs[10] = '{4'b0000, 4'b0010, 0, 0, 32, 127,  3, {7'd0, 7'd0, 7'd40, 7'd0},  4'b0010};
        vecs[11] = '{4'b0010, 4'b0000, 0, 0, 32, 127,  1, {7'd0, 7'd0, 7'd40, 7'd0},  4'b0010};
        vecs[12] = '{4'b0000, 4'b0000, 0, 0, 32, 127,  4, {7'd0, 7'd0, 7'd41, 7'd0},  4'b0010};
        vecs[13] = '{4'b0100, 4'b0100, 0, 0, 32, 127,  1, {7'd0, 7'd0, 7'd41, 7'd0},  4'b0110};
        vecs[14] = '{4'b0000, 4'b0000, 0, 0, 32, 127,  4, {7'd0, 7'd1, 7'd42, 7'd0},  4'b0110};

        rst = 1'b0; sample_rate = 1'b0; gate_on = '0; gate_off = '0;
        adsr_a = '0; adsr_d = '0; adsr_s = 7'd64; adsr_r = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_env_out", 32'(env_out), 0);
        chk("reset_env_dv", 32'(env_dv), 0);
        chk("reset_active", 32'(voice_active), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_overrun", 32'(overrun), 0);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            adsr_a = 7'(vecs[i].a); adsr_d = 7'(vecs[i].d);
            adsr_s = 7'(vecs[i].s); adsr_r = 7'(vecs[i].r);
            if (vecs[i].on != '0 || vecs[i].off != '0) pulse(vecs[i].on, vecs[i].off);
            for (int k = 0; k < vecs[i].n; k++) run_sample();
            @(negedge clk);
            chk($sformatf("vec%0d_env", i), 32'(env_out), 32'(vecs[i].env));
            chk($sformatf("vec%0d_active", i), 32'(voice_active), 32'(vecs[i].act));
        end

        // Strobe-to-env_dv latency, busy width, gate on the voice-3 service cycle
        push_expected();
        @(posedge clk); #1 sample_rate = 1'b1;
        @(posedge clk); #1 sample_rate = 1'b0;
        busy_cnt = 0; dv_at = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (env_dv) begin
                if (dv_at == 0) dv_at = c;
                sb_check();
            end
            if (c == 4) gate_on = 4'b1000;
            if (c == 5) begin
                gate_on = '0;
                chk("late_gate_not_yet_active", 32'(voice_active[3]), 0);
            end
        end
        m_pon[3] = 1;
        chk("busy_cycles", busy_cnt, 4);
        chk("strobe_to_dv", dv_at, 5);
        run_sample();
        chk("late_gate_next_sweep", 32'(voice_active[3]), 1);

        // Overrun: strobe held over the first busy cycle
        chk("overrun_initially_clear", 32'(overrun), 0);
        push_expected();
        @(posedge clk); #1 sample_rate = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 sample_rate = 1'b0;
        dv_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (env_dv) begin dv_cnt++; sb_check(); end
        end
        chk("overrun_single_sweep", dv_cnt, 1);
        chk("overrun_set", 32'(overrun), 1);
        run_sample();
        chk("overrun_sticky", 32'(overrun), 1);

        // Reset in the middle of a sweep
        push_expected();
        @(posedge clk); #1 sample_rate = 1'b1;
        @(posedge clk); #1 sample_rate = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_mid_sweep", 32'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_env_out", 32'(env_out), 0);
        chk("midrst_env_dv", 32'(env_dv), 0);
        chk("midrst_active", 32'(voice_active), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_overrun", 32'(overrun), 0);
        rst = 1'b1;
        sb_q.delete();
        model_reset();
        dv_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (env_dv) dv_cnt++;
        end
        chk("no_dv_after_abort", dv_cnt, 0);
        run_sample();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
